// File: rtl/window_buffer_5x5.sv
// -----------------------------------------------------------------------------
// window_buffer_5x5
//
// Streaming 5x5 sliding-window generator for a single feature-map channel.
// Pixels arrive in raster order (row-major, column 0 first). Every fully
// populated 5x5 neighbourhood is presented on a flat, registered bus one
// cycle after its bottom-right (newest) pixel is accepted.
//
// Handshake: push-only stream with no backpressure. A pixel is transferred
// on every rising clk edge where valid_in=1; nothing moves when valid_in=0.
// valid_out is a one-cycle qualifier for window_flat, and the consumer must
// take the window in every cycle that valid_out=1.
//
// Parameters
//   DATA_W  pixel width, signed two's complement
//   IMG_W   pixels per row   (>= 5)
//   IMG_H   rows per frame   (>= 5)
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   valid_in     in   pixel_in is valid this cycle
//   pixel_in     in   [DATA_W-1:0] signed input pixel
//   window_flat  out  [25*DATA_W-1:0] element (r,c) at bits
//                     [(r*5+c)*DATA_W +: DATA_W]; r=0 oldest row,
//                     c=0 leftmost column, element 24 = newest pixel
//   valid_out    out  one-cycle pulse: window_flat holds a new window
//   frame_done   out  one-cycle pulse with the window of the last pixel
// -----------------------------------------------------------------------------
module window_buffer_5x5 #(
  parameter int DATA_W = 14,
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     pixel_in,
  output logic [25*DATA_W-1:0]  window_flat,
  output logic                  valid_out,
  output logic                  frame_done
);

  // Four full rows plus five pixels cover every tap of a 5x5 window whose
  // newest pixel is the one being accepted.
  localparam int SR_LEN = 4 * IMG_W + 5;
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  // ---------------------------------------------------------------------------
  // Position counters: location of the pixel being accepted this cycle.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last;
  logic          row_last;
  logic          eligible;
  logic          last_px;

  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign last_px  = col_last && row_last;

  // Gating on row>=4 and col>=4 means every tap of an emitted window was
  // written during the current frame and the current five-row band, so no
  // window ever straddles a row edge, a frame edge, or pre-reset storage.
  assign eligible = (row >= RW'(4)) && (col >= CW'(4));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row <= '0;
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel shift register, sr[0] = newest. Deliberately not reset: the
  // eligibility gating keeps stale contents from ever reaching the output.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] sr      [SR_LEN];
  logic [DATA_W-1:0] sr_next [SR_LEN];

  always_comb begin
    sr_next[0] = pixel_in;
    for (int i = 1; i < SR_LEN; i++) begin
      sr_next[i] = sr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (valid_in) begin
      for (int i = 0; i < SR_LEN; i++) begin
        sr[i] <= sr_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Window tap selection. Taps come from the post-shift view so the pixel
  // accepted this cycle lands directly in element 24.
  // ---------------------------------------------------------------------------
  logic [25*DATA_W-1:0] win_next;

  always_comb begin
    win_next = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        win_next[(r*5+c)*DATA_W +: DATA_W] = sr_next[(4-r)*IMG_W + (4-c)];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. window_flat only loads on an emitted window, so it
  // holds the last window between pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out   <= 1'b0;
      frame_done  <= 1'b0;
      window_flat <= '0;
    end else begin
      valid_out  <= valid_in && eligible;
      frame_done <= valid_in && last_px;
      if (valid_in && eligible) begin
        window_flat <= win_next;
      end
    end
  end

endmodule

// File: tb/tb_window_buffer_5x5.sv
// -----------------------------------------------------------------------------
// tb_window_buffer_5x5
//
// Directed and gated-random stimulus for window_buffer_5x5. The bench holds
// each frame as a 2-D image and builds expected windows straight from image
// coordinates; expected words are queued when a pixel is driven and popped
// when the DUT raises valid_out.
// -----------------------------------------------------------------------------
module tb_window_buffer_5x5;

  localparam int DW = 14;
  localparam int IW = 12;
  localparam int IH = 12;
  localparam int NPIX = IW * IH;
  localparam int WIN_W = 25 * DW;
  localparam int W = WIN_W + 1;   // {frame_done, window}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               valid_in = 1'b0;
  logic [DW-1:0]      pixel_in = '0;
  logic [WIN_W-1:0]   window_flat;
  logic               valid_out;
  logic               frame_done;

  always #5 clk = ~clk;

  window_buffer_5x5 #(
    .DATA_W (DW),
    .IMG_W  (IW),
    .IMG_H  (IH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .pixel_in    (pixel_in),
    .window_flat (window_flat),
    .valid_out   (valid_out),
    .frame_done  (frame_done)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0]     exp_q[$];
  logic [WIN_W-1:0] hold_win;
  logic [DW-1:0]    img [NPIX];
  int               vectors = 0;
  int               miscompares = 0;

  function automatic logic [W-1:0] model_win(input int r, input int c, input bit last);
    logic [W-1:0] w;
    w = '0;
    for (int rr = 0; rr < 5; rr++) begin
      for (int cc = 0; cc < 5; cc++) begin
        w[(rr*5+cc)*DW +: DW] = img[(r-4+rr)*IW + (c-4+cc)];
      end
    end
    w[W-1] = last;
    return w;
  endfunction

  task automatic fill_img(input int base);
    for (int i = 0; i < NPIX; i++) begin
      img[i] = DW'(base + i);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock of stimulus, then check the registered response.
  // ---------------------------------------------------------------------------
  task automatic step(input logic v, input logic [DW-1:0] px, input logic push,
                      input logic [W-1:0] exp_word);
    logic [W-1:0] e;
    logic         exp_v;
    valid_in = v;
    pixel_in = px;
    @(posedge clk);
    if (v && push) exp_q.push_back(exp_word);
    @(negedge clk);
    valid_in = 1'b0;
    exp_v = (exp_q.size() != 0);
    vectors++;
    assert (valid_out === exp_v)
      else begin miscompares++; $error("FAIL valid_out obs=%b exp=%b", valid_out, exp_v); end
    if (exp_v) begin
      e = exp_q.pop_front();
      vectors++;
      assert (window_flat === e[WIN_W-1:0])
        else begin miscompares++; $error("FAIL window obs=%h exp=%h", window_flat, e[WIN_W-1:0]); end
      vectors++;
      assert (frame_done === e[W-1])
        else begin miscompares++; $error("FAIL frame_done obs=%b exp=%b", frame_done, e[W-1]); end
      hold_win = e[WIN_W-1:0];
    end else begin
      vectors++;
      assert (frame_done === 1'b0)
        else begin miscompares++; $error("FAIL frame_done_idle obs=%b exp=0", frame_done); end
      vectors++;
      assert (window_flat === hold_win)
        else begin miscompares++; $error("FAIL window_hold obs=%h exp=%h", window_flat, hold_win); end
    end
  endtask

  // Drives one full frame from img[], optionally with random idle gaps, and
  // checks first-window corners, per-row pulse counts and frame_done count.
  task automatic run_frame(input bit gated, input logic [DW-1:0] e0, input logic [DW-1:0] e24);
    int  row_cnt [IH];
    int  fd_cnt;
    int  total;
    bit  first;
    int  r;
    int  c;
    fd_cnt = 0;
    total  = 0;
    first  = 1'b1;
    for (int i = 0; i < IH; i++) row_cnt[i] = 0;
    for (int idx = 0; idx < NPIX; idx++) begin
      r = idx / IW;
      c = idx % IW;
      if (gated) begin
        while ($urandom_range(0, 1) == 0) begin
          step(1'b0, DW'($urandom), 1'b0, '0);
        end
      end
      step(1'b1, img[idx], (r >= 4) && (c >= 4), model_win(r, c, idx == NPIX - 1));
      if (valid_out === 1'b1) begin
        row_cnt[r]++;
        total++;
        if (first) begin
          first = 1'b0;
          vectors++;
          assert (window_flat[0 +: DW] === e0)
            else begin miscompares++; $error("FAIL first_e0 obs=%h exp=%h", window_flat[0 +: DW], e0); end
          vectors++;
          assert (window_flat[24*DW +: DW] === e24)
            else begin miscompares++; $error("FAIL first_e24 obs=%h exp=%h", window_flat[24*DW +: DW], e24); end
        end
      end
      if (frame_done === 1'b1) fd_cnt++;
    end
    for (int i = 0; i < IH; i++) begin
      vectors++;
      assert (row_cnt[i] === ((i >= 4) ? IW - 4 : 0))
        else begin miscompares++; $error("FAIL row_pulses row=%0d obs=%0d exp=%0d", i, row_cnt[i], (i >= 4) ? IW - 4 : 0); end
    end
    vectors++;
    assert (total === (IW - 4) * (IH - 4))
      else begin miscompares++; $error("FAIL total_pulses obs=%0d exp=%0d", total, (IW - 4) * (IH - 4)); end
    vectors++;
    assert (fd_cnt === 1)
      else begin miscompares++; $error("FAIL frame_done_count obs=%0d exp=1", fd_cnt); end
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    assert (valid_out === 1'b0)
      else begin miscompares++; $error("FAIL %s valid_out obs=%b exp=0", tag, valid_out); end
    vectors++;
    assert (frame_done === 1'b0)
      else begin miscompares++; $error("FAIL %s frame_done obs=%b exp=0", tag, frame_done); end
    vectors++;
    assert (window_flat === '0)
      else begin miscompares++; $error("FAIL %s window obs=%h exp=0", tag, window_flat); end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    hold_win = '0;

    // Power-on reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // 1. Single frame, continuous valid_in, value = row*12+col
    fill_img(0);
    run_frame(1'b0, DW'(0), DW'(52));

    // 2. Same frame with 50% random gating
    run_frame(1'b1, DW'(0), DW'(52));

    // 3. Back-to-back frames, second at 1000+index
    fill_img(0);
    run_frame(1'b0, DW'(0), DW'(52));
    fill_img(1000);
    run_frame(1'b0, DW'(1000), DW'(1052));

    // 4. Reset after 30 pixels (valid_in held high through reset), then a full frame
    for (int i = 0; i < 30; i++) begin
      step(1'b1, DW'(2000 + i), 1'b0, '0);
    end
    rst_n    = 1'b0;
    valid_in = 1'b1;
    pixel_in = DW'(3333);
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_mid_a");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_mid_b");
    valid_in = 1'b0;
    rst_n    = 1'b1;
    hold_win = '0;
    fill_img(500);
    run_frame(1'b0, DW'(500), DW'(552));

    // 5. Signed extremes pass through unchanged
    for (int i = 0; i < NPIX; i++) img[i] = '0;
    img[0]  = 14'h2000;
    img[52] = 14'h1FFF;
    run_frame(1'b1, 14'h2000, 14'h1FFF);

    // A few idle cycles: window must hold, no pulses
    repeat (4) step(1'b0, DW'($urandom), 1'b0, '0);

    vectors++;
    assert (exp_q.size() === 0)
      else begin miscompares++; $error("FAIL queue_drain obs=%0d exp=0", exp_q.size()); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the run always ends on its own
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/window_buffer_5x5.md
# window_buffer_5x5

Streaming 5x5 sliding-window generator for one feature-map channel. It accepts signed pixels in raster order and presents every fully populated 5x5 neighbourhood as a flat bus. Three instances, one per channel, feed the layer-2 depthwise convolution stage. Window contents, valid pulse and frame bookkeeping are produced here; the convolution stage performs no buffering of its own.

## Interface
- DATA_W, 14, pixel width (signed, two's complement)
- IMG_W, 12, pixels per row (≥5)
- IMG_H, 12, rows per frame (≥5)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- valid_in  in  1  pixel_in is valid this cycle
- pixel_in  in  DATA_W  signed input pixel, raster order (row-major, col 0 first)
- window_flat  out  25*DATA_W  element (r,c) at bits [(r*5+c)*DATA_W +: DATA_W]; r=0 oldest row, c=0 leftmost column, element 24 = newest pixel
- valid_out  out  1  one-cycle pulse, window_flat holds a new complete window
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- Storage: shift register of 4*IMG_W+5 entries of DATA_W bits, sr[0] = newest. Shift occurs only on valid_in=1. Storage is not cleared by reset.
- Window mapping: element (r,c) = sr[(4-r)*IMG_W + (4-c)], sampled after the shift that includes the current pixel.
- Position counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the pixel being accepted. Both advance on valid_in only. col wraps to 0 at IMG_W-1 and row increments. When row=IMG_H-1 and col=IMG_W-1, both wrap to 0.
- Window emitted when the accepted pixel has row≥4 and col≥4. This gives (IMG_W-4)*(IMG_H-4) windows per frame, 64 at default parameters.
- No window spans a row boundary or a frame boundary. The row≥4/col≥4 gating guarantees this, so back-to-back frames need no flush.
- Data passes through bit-exact: no arithmetic, no truncation, sign preserved.
- valid_in=0: counters, storage and window_flat hold; valid_out=0; frame_done=0.
- No backpressure. The downstream stage must accept a window every cycle that valid_out=1.

## Timing
- Reset (rst_n=0 at a clk edge): row=0, col=0, valid_out=0, frame_done=0, window_flat=0. Reset overrides valid_in in the same cycle.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is treated as (0,0), and stale storage never reaches a valid window.
- Latency: 1 cycle. If valid_in=1 at edge N for pixel (row≥4, col≥4), then after edge N+1 valid_out=1 and window_flat holds rows row-4..row and columns col-4..col.
- window_flat is registered and holds its last value while valid_out=0.
- frame_done is asserted in the same cycle as valid_out for the last pixel (IMG_H-1, IMG_W-1). It is asserted for 1 cycle only.
- Throughput: 1 pixel per cycle. Continuous valid_in gives valid_out high on 8 consecutive cycles per eligible row at defaults, followed by 4 low cycles.

## Test plan
- Single 12x12 frame, pixel value = row*12+col, valid_in continuous -> first valid_out one cycle after pixel 52 is accepted. Element0=0, element4=4, element20=48, element24=52. Second window: element0=1, element24=53. Total 64 pulses. frame_done pulses once, coincident with the window whose element24=143.
- Same frame with valid_in gated by a pseudo-random 50% pattern -> identical sequence of 64 windows in the same order. No valid_out while valid_in=0.
- Two back-to-back frames, frame-2 values = 1000+index -> the first frame-2 window has element0=1000 and element24=1052. No window mixes 0..143 with 1000+ values. 128 pulses total, 2 frame_done pulses.
- Reset asserted after 30 pixels, then a full frame (values 500+index) -> valid_out=0 and window_flat=0 during reset. The first window appears after the 53rd post-reset pixel with element0=500.
- Signed extremes: pixel 0 = 0x2000 (-8192), pixel 52 = 0x1FFF (8191), rest 0 -> the first window has element0=0x2000 and element24=0x1FFF, unchanged.
- Column-edge check -> no valid_out for any pixel with col<4 or row<4. Counted per row: 0 pulses for rows 0-3, 8 pulses for each of rows 4-11.
